// File: rtl/ahb_arbiter.sv
// ahb_arbiter: AHB bus arbiter fed by the handover detector's `ho` pulse.
// Round-robin grant among requesting masters. The bus parks on DEF_MASTER
// when nobody requests. Locked sequences keep the grant until hlockx drops.
// Grant, address-phase owner and lock flag are all registered.
//
// Optional feature macro: ARB_FIXED_PRIO_EN
//   defined   -> lowest-index requester wins; the RR pointer stays at reset value
//   undefined -> round-robin search starting after the last winner
module ahb_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int DEF_MASTER  = 0
) (
    input  logic                   hclk,
    input  logic                   hrst_n,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlockx,
    input  logic                   hready,
    input  logic                   ho,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [3:0]             hmaster,
    output logic                   hmastlock
);

    localparam int IW = $clog2(NUM_MASTERS);

    typedef logic [IW-1:0] idx_t;
    typedef logic [IW:0]   pos_t;

    typedef enum logic [1:0] {
        PARK   = 2'd0,
        OWNED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // One-hot vector with a single bit set at index i.
    function automatic logic [NUM_MASTERS-1:0] onehot(input idx_t i);
        logic [NUM_MASTERS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    localparam idx_t                   DEF_IDX   = idx_t'(DEF_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = onehot(DEF_IDX);
    localparam pos_t                   NUM_POS   = pos_t'(NUM_MASTERS);

    // Elaboration-time parameter sanity checks.
    generate
        if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_num
            $error("ahb_arbiter: NUM_MASTERS must be in 2..16");
        end
        if (DEF_MASTER < 0 || DEF_MASTER >= NUM_MASTERS) begin : g_bad_def
            $error("ahb_arbiter: DEF_MASTER must be < NUM_MASTERS");
        end
    endgenerate

    state_t                 state;
    state_t                 state_n;
    logic [NUM_MASTERS-1:0] grant_n;
    idx_t                   ptr;
    idx_t                   ptr_n;
    idx_t                   cur;
    logic                   win_found;
    idx_t                   win_idx;
    logic                   win_lock;

    // Encode the current one-hot grant to the index of its owner.
    always_comb begin
        cur = DEF_IDX;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant[i]) begin
                cur = idx_t'(i);
            end
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest-index requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = DEF_IDX;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (hbusreq[i]) begin
                win_found = 1'b1;
                win_idx   = idx_t'(i);
            end
        end
    end
`else
    // Round-robin: scan from ptr+1 upward with wrap; ptr itself is checked
    // last so a lone requester can be re-granted.
    always_comb begin
        pos_t pos;
        win_found = 1'b0;
        win_idx   = DEF_IDX;
        pos       = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            pos = {1'b0, ptr} + pos_t'(k);
            if (pos >= NUM_POS) begin
                pos = pos - NUM_POS;
            end
            if (!win_found && hbusreq[pos[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = pos[IW-1:0];
            end
        end
    end
`endif

    assign win_lock = hlockx[win_idx];

    // Next-state logic. Everything holds while hready is low.
    always_comb begin
        state_n = state;
        grant_n = hgrant;
        ptr_n   = ptr;
        if (hready) begin
            case (state)
                PARK: begin
                    grant_n = DEF_GRANT;
                    if (win_found) begin
                        grant_n = onehot(win_idx);
`ifndef ARB_FIXED_PRIO_EN
                        ptr_n   = win_idx;
`endif
                        state_n = win_lock ? LOCKED : OWNED;
                    end
                end
                OWNED: begin
                    // Re-arbitrate on handover or when the owner stops asking.
                    if (ho || !hbusreq[cur]) begin
                        if (win_found) begin
                            grant_n = onehot(win_idx);
`ifndef ARB_FIXED_PRIO_EN
                            ptr_n   = win_idx;
`endif
                            state_n = win_lock ? LOCKED : OWNED;
                        end else begin
                            grant_n = DEF_GRANT;
                            state_n = PARK;
                        end
                    end
                end
                LOCKED: begin
                    // Grant is pinned until the owner drops its lock; the
                    // next arbitration happens from OWNED on a later cycle.
                    if (!hlockx[cur]) begin
                        state_n = OWNED;
                    end
                end
                default: begin
                    grant_n = DEF_GRANT;
                    state_n = PARK;
                end
            endcase
        end
    end

    // State, grant and pointer registers.
    always_ff @(posedge hclk) begin
        if (!hrst_n) begin
            state  <= PARK;
            hgrant <= DEF_GRANT;
            ptr    <= DEF_IDX;
        end else begin
            state  <= state_n;
            hgrant <= grant_n;
            ptr    <= ptr_n;
        end
    end

    // Address-phase owner follows the grant one hready-high cycle later.
    always_ff @(posedge hclk) begin
        if (!hrst_n) begin
            hmaster   <= 4'(DEF_IDX);
            hmastlock <= 1'b0;
        end else if (hready) begin
            hmaster   <= 4'(cur);
            hmastlock <= hlockx[cur];
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed scoreboard bench for ahb_arbiter (4 masters,
// default master 0). Stimulus queues the expected post-edge outputs; a
// monitor on the falling edge pops and compares them.
module tb_ahb_arbiter;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       hclk = 1'b0;
    logic       hrst_n;
    logic [3:0] hbusreq;
    logic [3:0] hlockx;
    logic       hready;
    logic       ho;
    logic [3:0] hgrant;
    logic [3:0] hmaster;
    logic       hmastlock;

    typedef struct {
        int         cyc;
        string      nm;
        logic [3:0] g;
        logic [3:0] m;
        logic       l;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;

    ahb_arbiter #(.NUM_MASTERS(4), .DEF_MASTER(0)) dut (
        .hclk      (hclk),
        .hrst_n    (hrst_n),
        .hbusreq   (hbusreq),
        .hlockx    (hlockx),
        .hready    (hready),
        .ho        (ho),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    always @(posedge hclk) cyc <= cyc + 1;

    // Monitor: compare outputs against the entry due this cycle.
    always @(negedge hclk) begin
        if (q.size() != 0 && q[0].cyc == cyc) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (hgrant === e.g && hmaster === e.m && hmastlock === e.l) begin
                passed++;
            end else begin
                $display("FAIL %s: got hgrant=%b hmaster=%0d hmastlock=%b, want hgrant=%b hmaster=%0d hmastlock=%b",
                         e.nm, hgrant, hmaster, hmastlock, e.g, e.m, e.l);
            end
        end
    end

    // Queue the outputs expected after the coming edge, then step past it.
    task automatic tick(input string nm, input logic [3:0] g,
                        input logic [3:0] m, input logic l);
        exp_t e;
        e.cyc = cyc + 1;
        e.nm  = nm;
        e.g   = g;
        e.m   = m;
        e.l   = l;
        q.push_back(e);
        @(posedge hclk);
        #1;
    endtask

    initial begin
        // Reset with all masters requesting.
        hrst_n = 1'b0; hbusreq = 4'b1111; hlockx = 4'b0000; hready = 1'b1; ho = 1'b0;
        tick("reset0", 4'b0001, 4'd0, 1'b0);
        tick("reset1", 4'b0001, 4'd0, 1'b0);

        // Release, nobody requesting: stay parked.
        hrst_n = 1'b1; hbusreq = 4'b0000;
        tick("park0", 4'b0001, 4'd0, 1'b0);
        tick("park1", 4'b0001, 4'd0, 1'b0);

        // Single request from master 1.
        hbusreq = 4'b0010;
        tick("req1_grant", 4'b0010, 4'd0, 1'b0);
        hready = 1'b0;
        tick("nrdy_hold0", 4'b0010, 4'd0, 1'b0);
        tick("nrdy_hold1", 4'b0010, 4'd0, 1'b0);
        tick("nrdy_hold2", 4'b0010, 4'd0, 1'b0);
        hready = 1'b1;
        tick("owner_upd", 4'b0010, 4'd1, 1'b0);

`ifdef ARB_FIXED_PRIO_EN
        // Fixed priority: master 1 keeps winning over 2 and 3.
        hbusreq = 4'b1110; ho = 1'b1;
        tick("fp0", 4'b0010, 4'd1, 1'b0);
        tick("fp1", 4'b0010, 4'd1, 1'b0);
        tick("fp2", 4'b0010, 4'd1, 1'b0);
        tick("fp3", 4'b0010, 4'd1, 1'b0);
`else
        // Round-robin rotation with a handover every cycle.
        hbusreq = 4'b1111; ho = 1'b1;
        tick("rr_to2", 4'b0100, 4'd1, 1'b0);
        tick("rr_to3", 4'b1000, 4'd2, 1'b0);
        tick("rr_wrap0", 4'b0001, 4'd3, 1'b0);
        tick("rr_to1", 4'b0010, 4'd0, 1'b0);
`endif

        // No handover: owner 1 keeps the bus.
        hbusreq = 4'b0110; ho = 1'b0;
        for (int i = 0; i < 5; i++) tick("no_ho", 4'b0010, 4'd1, 1'b0);

        // Handover while owner drops request; master 2 wins with a lock.
        hbusreq = 4'b0100; hlockx = 4'b0100; ho = 1'b1;
        tick("ho_lock_grant", 4'b0100, 4'd1, 1'b0);

        // Locked: ho and other requests ignored.
        hbusreq = 4'b1111;
        tick("locked0", 4'b0100, 4'd2, 1'b1);
        tick("locked1", 4'b0100, 4'd2, 1'b1);
        tick("locked2", 4'b0100, 4'd2, 1'b1);

        // Lock dropped: back to OWNED with same grant, no arbitration yet.
        hlockx = 4'b0000;
        tick("unlock_hold", 4'b0100, 4'd2, 1'b0);
        hbusreq = 4'b1000;
        tick("unlock_rearb", 4'b1000, 4'd2, 1'b0);

        // Owner 3 releases: park on master 0.
        ho = 1'b0;
        tick("own3", 4'b1000, 4'd3, 1'b0);
        hbusreq = 4'b0000;
        tick("release_park", 4'b0001, 4'd3, 1'b0);
        tick("parked", 4'b0001, 4'd0, 1'b0);

        // Lone requester is re-granted on handover.
        hbusreq = 4'b0001;
        tick("req0", 4'b0001, 4'd0, 1'b0);
        ho = 1'b1;
        tick("regrant0", 4'b0001, 4'd0, 1'b0);

        // Lock then reset mid-lock.
        hbusreq = 4'b0100; hlockx = 4'b0100;
        tick("lock2_grant", 4'b0100, 4'd0, 1'b0);
        ho = 1'b0;
        tick("lock2_owner", 4'b0100, 4'd2, 1'b1);
        hrst_n = 1'b0;
        tick("reset_midlock", 4'b0001, 4'd0, 1'b0);
        hrst_n = 1'b1; hbusreq = 4'b0000; hlockx = 4'b0000;
        tick("post_reset_park", 4'b0001, 4'd0, 1'b0);

        // Pointer back at master 0 after reset.
        hbusreq = 4'b0011;
        tick("ptr_after_reset", FIXED ? 4'b0001 : 4'b0010, 4'd0, 1'b0);
        tick("ptr_after_hold", FIXED ? 4'b0001 : 4'b0010, FIXED ? 4'd0 : 4'd1, 1'b0);

        // ho ignored while hready is low.
        hready = 1'b0; ho = 1'b1;
        tick("nrdy_ho_ignored", FIXED ? 4'b0001 : 4'b0010, FIXED ? 4'd0 : 4'd1, 1'b0);
        hready = 1'b1;
        tick("rdy_ho_wrap", 4'b0001, FIXED ? 4'd0 : 4'd1, 1'b0);

        @(negedge hclk);
        #1;
        total++;
        if (q.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
